sha2indctrl: RTL and testbench
==============================

# sha2indctrl

Sequencing FSM for the SHA-256 input datapath (packet mux, 8×64-bit block register file, slot counter, length register). It accepts 64-bit message packets over a valid/ready handshake and drives the datapath strobes `clr`, `st_pkt`, `pad_pkt`, `zero_pkt`, `mgln_pkt`. It appends SHA-256 padding: the pad word, zero words and the 64-bit length word, adding an extra block when needed. Each completed 512-bit block is presented to the compression core through a valid/ack handshake.

## Interface
- `IW`, 3, slot index width; a block holds 2^IW packets, the last slot is 2^IW−1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `msg_vld` in 1: upstream presents a message packet on the datapath `pkt` bus.
- `msg_last` in 1: the presented packet is the final one of the message.
- `msg_rdy` out 1: controller accepts the packet; transfer = `msg_vld & msg_rdy`.
- `idx` in IW: current slot index from the datapath counter.
- `clr` out 1: clears the slot counter and length register.
- `st_pkt` out 1: store the packet-mux output into slot `idx`.
- `pad_pkt`, `zero_pkt`, `mgln_pkt` out 1 each: packet-mux select; at most one is high, and only together with `st_pkt`.
- `blk_vld` out 1: `blk` holds a complete block.
- `blk_last` out 1: the block is the final block of the message; meaningful only while `blk_vld`=1.
- `blk_ack` in 1: core consumed the block.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, MSG, PAD, ZERO, LEN, WAIT. Registers: `state`, `resume` (a state), `fin` (1 bit).
- All outputs are decoded from `state` (Moore), except `st_pkt` in MSG, which is `msg_vld`.
- **IDLE**: `clr`=1, all else 0. On `msg_vld`, go to MSG. The packet is not accepted in that cycle.
- **MSG**: `msg_rdy`=1. On transfer: `st_pkt`=1, mux selects message.
  - If `idx`=last slot: go to WAIT; `resume`=PAD if `msg_last`, else MSG; `fin`=0.
  - Else if `msg_last`: go to PAD.
  - No transfer: hold.
- **PAD**: `st_pkt`=`pad_pkt`=1.
  - `idx`=last slot: go to WAIT, `resume`=ZERO, `fin`=0.
  - `idx`=last−1: go to LEN.
  - Otherwise: go to ZERO.
- **ZERO**: `st_pkt`=`zero_pkt`=1. Go to LEN when `idx`=last−1; otherwise hold.
- **LEN**: `st_pkt`=`mgln_pkt`=1; `idx` is the last slot here. Go to WAIT, `resume`=IDLE, `fin`=1.
- **WAIT**: `blk_vld`=1, `blk_last`=`fin`, `msg_rdy`=0, no strobes. On `blk_ack`, go to `resume`.
- The datapath counter wraps from the last slot to 0 on the storing edge. The controller never stores into slot 0 of a new block before `blk_ack`.
- `msg_last` is ignored unless a transfer occurs.

## Timing
- Reset: state=IDLE, `resume`=IDLE, `fin`=0.
  - Outputs during and after reset: `clr`=1; `msg_rdy`, `st_pkt`, the three mux selects, `blk_vld`, `blk_last` and `busy` = 0.
- Reset mid-operation returns to IDLE immediately. The block in progress is discarded; `clr` re-zeroes the datapath.
- One packet is stored per cycle in MSG (when `msg_vld`=1), PAD, ZERO and LEN.
- `blk_vld` rises the cycle after the slot-7 store edge, when `blk` is stable. It holds until `blk_ack` is sampled high.
- `blk_ack` while `blk_vld`=0 is ignored.
- `blk_ack` in WAIT gives a store in the next state on the following cycle (zero bubble).
- Latency: a 1-packet message (`msg_last` accepted in cycle T) gives `blk_vld` in cycle T+8.

## Configuration
- `SHA2IND_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in any state forces next state IDLE, `resume`=IDLE, `fin`=0.
  - In that cycle: `st_pkt`, `msg_rdy` and `blk_vld` are forced to 0.
  - `abort` takes priority over every other transition.
- Macro undefined: no `abort` port and no logic for it.

## Structure
- Shared package `sha2ind_pkg` holds:
  - the state enum `sha2ind_st_t`;
  - constants `SHA2IND_IW`=3, `SHA2IND_LAST`=7, `SHA2IND_LENSLOT`=7.
- Single module, with one sequential and one combinational next-state/output process. No sub-module is needed.

## Test plan
- 1-packet message (`msg_last` in the first transfer), ack immediately:
  - stores: message at slot 0, pad at 1, zero at 2–6, length at 7;
  - `blk_vld`=1, `blk_last`=1, then IDLE.
- 6-packet message: pad at slot 6, length at slot 7 in the next cycle, no zero strobe; one block with `blk_last`=1.
- 7-packet message: pad at slot 7; `blk_vld`=1, `blk_last`=0. After ack: zero at 0–6, length at 7; `blk_vld`=1, `blk_last`=1.
- 8-packet message: full block with `blk_last`=0. After ack: pad at 0, zero at 1–6, length at 7, `blk_last`=1.
- Backpressure:
  - `msg_vld` gaps in MSG give no `st_pkt`;
  - `blk_ack` withheld for 5 cycles keeps `blk_vld` high, `msg_rdy`=0 and no strobes;
  - `rst` pulsed in ZERO gives IDLE with `clr`=1 the same cycle.
- `SHA2IND_ABORT_EN`: `abort` pulsed in WAIT gives IDLE next cycle, `blk_vld`=0 and no store. A following 1-packet message completes normally.

Source files
------------

// File: rtl/sha2ind_pkg.sv
// Shared definitions for the SHA-256 input sequencing controller:
// FSM state type and slot-geometry constants.
package sha2ind_pkg;

    localparam int SHA2IND_IW      = 3;   // slot index width
    localparam int SHA2IND_LAST    = 7;   // last slot of a block
    localparam int SHA2IND_LENSLOT = 7;   // slot that carries the 64-bit length

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MSG  = 3'd1,
        ST_PAD  = 3'd2,
        ST_ZERO = 3'd3,
        ST_LEN  = 3'd4,
        ST_WAIT = 3'd5
    } sha2ind_st_t;

endpackage

// File: rtl/sha2indctrl_if.sv
// Handshake bundle between upstream message source, the sequencing
// controller and the compression core.
//
// Handshake rules:
//   message side : msg_vld/msg_last driven by upstream, msg_rdy by the
//                  controller; a packet moves on a rising edge where
//                  msg_vld & msg_rdy. msg_last is only looked at on a transfer.
//   block side   : blk_vld/blk_last driven by the controller, blk_ack by the
//                  core; blk_vld stays high until blk_ack is sampled high,
//                  and blk_ack while blk_vld=0 has no effect.
// The slave modport is the controller's view, master is the environment's.
interface sha2indctrl_if;

    logic msg_vld;
    logic msg_last;
    logic msg_rdy;
    logic blk_vld;
    logic blk_last;
    logic blk_ack;

    modport slave (
        input  msg_vld,
        input  msg_last,
        output msg_rdy,
        output blk_vld,
        output blk_last,
        input  blk_ack
    );

    modport master (
        output msg_vld,
        output msg_last,
        input  msg_rdy,
        input  blk_vld,
        input  blk_last,
        output blk_ack
    );

endinterface

// File: rtl/sha2indctrl.sv
// Sequencing FSM for the SHA-256 input datapath. Accepts 64-bit message
// packets, then fills the block with the pad word, zero words and the
// length word (in the last slot), spilling into an extra block when the
// pad or length does not fit. Each finished block is offered to the core
// with blk_vld and held until blk_ack.
// Optional feature: define SHA2IND_ABORT_EN to add the `abort` input,
// which returns the controller to IDLE from any state.
module sha2indctrl
    import sha2ind_pkg::*;
#(
    parameter int IW = SHA2IND_IW
) (
    input  logic                clk,
    input  logic                rst,
`ifdef SHA2IND_ABORT_EN
    input  logic                abort,
`endif
    sha2indctrl_if.slave        bus,
    input  logic [IW-1:0]       idx,
    output logic                clr,
    output logic                st_pkt,
    output logic                pad_pkt,
    output logic                zero_pkt,
    output logic                mgln_pkt,
    output logic                busy,
    output sha2ind_st_t         dbg_state
);

    // Last slot and the one before it; the length word always goes last.
    localparam logic [IW-1:0] LAST_IDX    = {IW{1'b1}};
    localparam logic [IW-1:0] PRELAST_IDX = {{(IW-1){1'b1}}, 1'b0};

    sha2ind_st_t state, state_n;
    sha2ind_st_t resume, resume_n;
    logic        fin, fin_n;

    logic rdy_c, vld_c, last_c;

    // State, resume target and final-block flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            resume <= ST_IDLE;
            fin    <= 1'b0;
        end else begin
            state  <= state_n;
            resume <= resume_n;
            fin    <= fin_n;
        end
    end

    // Next-state and Moore output decode; st_pkt in MSG follows msg_vld.
    always_comb begin
        state_n  = state;
        resume_n = resume;
        fin_n    = fin;
        clr      = 1'b0;
        rdy_c    = 1'b0;
        st_pkt   = 1'b0;
        pad_pkt  = 1'b0;
        zero_pkt = 1'b0;
        mgln_pkt = 1'b0;
        vld_c    = 1'b0;
        last_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                // The first packet is only seen here, accepted from MSG.
                clr = 1'b1;
                if (bus.msg_vld) state_n = ST_MSG;
            end
            ST_MSG: begin
                rdy_c  = 1'b1;
                st_pkt = bus.msg_vld;
                if (bus.msg_vld) begin
                    if (idx == LAST_IDX) begin
                        state_n  = ST_WAIT;
                        resume_n = bus.msg_last ? ST_PAD : ST_MSG;
                        fin_n    = 1'b0;
                    end else if (bus.msg_last) begin
                        state_n = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                st_pkt  = 1'b1;
                pad_pkt = 1'b1;
                if (idx == LAST_IDX) begin
                    // No room for the length: it goes into an extra block.
                    state_n  = ST_WAIT;
                    resume_n = ST_ZERO;
                    fin_n    = 1'b0;
                end else if (idx == PRELAST_IDX) begin
                    state_n = ST_LEN;
                end else begin
                    state_n = ST_ZERO;
                end
            end
            ST_ZERO: begin
                st_pkt   = 1'b1;
                zero_pkt = 1'b1;
                if (idx == PRELAST_IDX) state_n = ST_LEN;
            end
            ST_LEN: begin
                st_pkt   = 1'b1;
                mgln_pkt = 1'b1;
                state_n  = ST_WAIT;
                resume_n = ST_IDLE;
                fin_n    = 1'b1;
            end
            ST_WAIT: begin
                vld_c  = 1'b1;
                last_c = fin;
                if (bus.blk_ack) state_n = resume;
            end
            default: begin
                state_n  = ST_IDLE;
                resume_n = ST_IDLE;
                fin_n    = 1'b0;
            end
        endcase
`ifdef SHA2IND_ABORT_EN
        // Abort wins over every transition and suppresses all activity.
        if (abort) begin
            state_n  = ST_IDLE;
            resume_n = ST_IDLE;
            fin_n    = 1'b0;
            st_pkt   = 1'b0;
            pad_pkt  = 1'b0;
            zero_pkt = 1'b0;
            mgln_pkt = 1'b0;
            rdy_c    = 1'b0;
            vld_c    = 1'b0;
            last_c   = 1'b0;
        end
`endif
    end

    assign bus.msg_rdy  = rdy_c;
    assign bus.blk_vld  = vld_c;
    assign bus.blk_last = last_c;
    assign busy         = (state != ST_IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_sha2indctrl.sv
// Bench for sha2indctrl: emulates the datapath slot counter, drives random
// messages, and compares every cycle against a store-sequence model built
// from the padding rules (message words, pad, zeros, length in last slot).
module tb_sha2indctrl;
    import sha2ind_pkg::*;

    localparam int IW     = SHA2IND_IW;
    localparam int SLOTS  = 1 << IW;
    localparam int K_MSG  = 0;
    localparam int K_PAD  = 1;
    localparam int K_ZERO = 2;
    localparam int K_LEN  = 3;

    logic          clk;
    logic          rst;
    logic [IW-1:0] idx;
    logic          clr, st_pkt, pad_pkt, zero_pkt, mgln_pkt, busy;
    sha2ind_st_t   dbg_state;
`ifdef SHA2IND_ABORT_EN
    logic          abort;
`endif

    sha2indctrl_if bus();

    sha2indctrl #(.IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SHA2IND_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .idx       (idx),
        .clr       (clr),
        .st_pkt    (st_pkt),
        .pad_pkt   (pad_pkt),
        .zero_pkt  (zero_pkt),
        .mgln_pkt  (mgln_pkt),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath slot counter: cleared by clr, advances and wraps per store.
    always @(posedge clk or posedge rst) begin
        if (rst)         idx <= '0;
        else if (clr)    idx <= '0;
        else if (st_pkt) idx <= idx + IW'(1);
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [1:0] exp_q[$];     // expected store kinds, in order
    logic       last_q[$];    // expected blk_last per block
    bit         m_busy = 0;
    bit         m_full = 0;
    int         m_cnt  = 0;
    int         t_last = 0;
    int         n_st, n_zero, n_blk, first_last, lat, first_vld_cycles;
    logic       prev_vld = 1'b0;
    int         ack_mode = 0;
    int         hold_cnt = 0;

    // Per-cycle comparison against the store-sequence model.
    always @(negedge clk) begin : compare
        logic       ab;
        logic       e_rdy, e_st, e_vld;
        int         kind;
        logic [2:0] e_sel, sel;
        ab = 1'b0;
`ifdef SHA2IND_ABORT_EN
        ab = abort;
`endif
        sel = {mgln_pkt, zero_pkt, pad_pkt};
        if (rst) begin
            chk("rst_clr", int'(clr), 1);
            chk("rst_busy", int'(busy), 0);
            chk("rst_rdy", int'(bus.msg_rdy), 0);
            chk("rst_st", int'(st_pkt), 0);
            chk("rst_vld", int'(bus.blk_vld), 0);
            exp_q.delete();
            last_q.delete();
            m_busy   = 0;
            m_full   = 0;
            m_cnt    = 0;
            prev_vld = 1'b0;
        end else begin
            kind  = (exp_q.size() > 0) ? int'(exp_q[0]) : -1;
            e_vld = m_busy && m_full && !ab;
            e_rdy = m_busy && !m_full && (kind == K_MSG) && !ab;
            e_st  = m_busy && !m_full && (kind >= 0) &&
                    (kind != K_MSG || bus.msg_vld) && !ab;
            chk("busy", int'(busy), int'(m_busy));
            chk("clr", int'(clr), int'(!m_busy));
            chk("msg_rdy", int'(bus.msg_rdy), int'(e_rdy));
            chk("blk_vld", int'(bus.blk_vld), int'(e_vld));
            chk("st_pkt", int'(st_pkt), int'(e_st));
            if (bus.blk_vld && e_vld && last_q.size() > 0)
                chk("blk_last", int'(bus.blk_last), int'(last_q[0]));
            if (st_pkt && e_st) begin
                case (kind)
                    K_PAD:   e_sel = 3'b001;
                    K_ZERO:  e_sel = 3'b010;
                    K_LEN:   e_sel = 3'b100;
                    default: e_sel = 3'b000;
                endcase
                chk("store_kind", int'(sel), int'(e_sel));
                chk("store_slot", int'(idx), m_cnt);
                n_st++;
                if (kind == K_ZERO) n_zero++;
                if (kind == K_MSG && bus.msg_last) t_last = cyc;
            end else if (!st_pkt) begin
                chk("sel_quiet", int'(sel), 0);
            end
            if (bus.blk_vld && !prev_vld) begin
                n_blk++;
                if (n_blk == 1) begin
                    first_last = int'(bus.blk_last);
                    lat        = cyc - t_last;
                end
            end
            if (bus.blk_vld && n_blk == 1) first_vld_cycles++;
            prev_vld = bus.blk_vld;
            // advance the model to the next cycle
            if (ab) begin
                exp_q.delete();
                last_q.delete();
                m_busy = 0;
                m_full = 0;
                m_cnt  = 0;
            end else if (!m_busy) begin
                if (bus.msg_vld) m_busy = 1;
            end else if (m_full) begin
                if (bus.blk_ack) begin
                    m_full = 0;
                    if (last_q.size() > 0) void'(last_q.pop_front());
                    if (exp_q.size() == 0) m_busy = 0;
                end
            end else if (e_st) begin
                void'(exp_q.pop_front());
                m_cnt++;
                if (m_cnt == SLOTS) begin
                    m_cnt  = 0;
                    m_full = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic int blocks_for(input int n);
        int k;
        k = (SLOTS - ((n + 2) % SLOTS)) % SLOTS;
        return (n + 2 + k) / SLOTS;
    endfunction

    task automatic start_msg(input int n);
        int k, nb;
        k  = (SLOTS - ((n + 2) % SLOTS)) % SLOTS;
        nb = (n + 2 + k) / SLOTS;
        for (int i = 0; i < n; i++) exp_q.push_back(2'(K_MSG));
        exp_q.push_back(2'(K_PAD));
        for (int i = 0; i < k; i++) exp_q.push_back(2'(K_ZERO));
        exp_q.push_back(2'(K_LEN));
        for (int b = 0; b < nb; b++) last_q.push_back(b == nb - 1);
        n_st = 0; n_zero = 0; n_blk = 0;
        first_last = -1; lat = -1; first_vld_cycles = 0;
    endtask

    task automatic drive_msg(input int n, input int gap_pct);
        int sent, guard;
        sent = 0;
        guard = 0;
        while (sent < n && guard < 2000) begin
            bus.msg_vld  = ($urandom_range(0, 99) >= gap_pct);
            bus.msg_last = bus.msg_vld ? (sent == n - 1) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.msg_vld && bus.msg_rdy) sent++;
            @(posedge clk); #1;
            guard++;
        end
        bus.msg_vld  = 1'b0;
        bus.msg_last = 1'b0;
        chk("drive_done", sent, n);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || m_busy || exp_q.size() > 0) && g < 400) begin
            @(posedge clk); #1;
            g++;
        end
        chk("idle_reached", int'(g < 400), 1);
    endtask

    task automatic send_msg(input int n, input int gap_pct);
        start_msg(n);
        drive_msg(n, gap_pct);
        wait_idle();
        @(posedge clk); #1;
    endtask

    // Block acknowledge: 0 immediate, 1 random, 2 never, 3 after 5 held cycles.
    initial begin
        bus.blk_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.blk_vld) hold_cnt++;
            else             hold_cnt = 0;
            case (ack_mode)
                0:       bus.blk_ack = 1'b1;
                1:       bus.blk_ack = 1'($urandom_range(0, 1));
                2:       bus.blk_ack = 1'b0;
                default: bus.blk_ack = (hold_cnt >= 6);
            endcase
        end
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int n, nb, g;
        rst          = 1'b1;
        bus.msg_vld  = 1'b0;
        bus.msg_last = 1'b0;
`ifdef SHA2IND_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_clr", int'(clr), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sel", int'({st_pkt, pad_pkt, zero_pkt, mgln_pkt}), 0);
        chk("reset_blk", int'({bus.blk_vld, bus.blk_last, bus.msg_rdy}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1-packet message, immediate ack
        ack_mode = 0;
        send_msg(1, 0);
        chk("m1_stores", n_st, 8);
        chk("m1_zeros", n_zero, 5);
        chk("m1_blocks", n_blk, 1);
        chk("m1_last", first_last, 1);
        chk("m1_latency", lat, 8);

        // 6 packets: pad at 6, length at 7, no zeros
        send_msg(6, 0);
        chk("m6_stores", n_st, 8);
        chk("m6_zeros", n_zero, 0);
        chk("m6_blocks", n_blk, 1);
        chk("m6_last", first_last, 1);

        // 7 packets: pad closes block 1, extra block of zeros + length
        send_msg(7, 0);
        chk("m7_stores", n_st, 16);
        chk("m7_zeros", n_zero, 7);
        chk("m7_blocks", n_blk, 2);
        chk("m7_first_last", first_last, 0);

        // 8 packets with valid gaps: full message block, then pad block
        send_msg(8, 30);
        chk("m8_stores", n_st, 16);
        chk("m8_zeros", n_zero, 6);
        chk("m8_blocks", n_blk, 2);
        chk("m8_first_last", first_last, 0);

        // ack withheld for 5 cycles
        ack_mode = 3;
        send_msg(1, 50);
        chk("hold_vld_cycles", first_vld_cycles, 6);
        ack_mode = 0;

        // reset while filling zeros
        start_msg(1);
        drive_msg(1, 0);
        g = 0;
        while (!zero_pkt && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("zero_seen", int'(zero_pkt), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_clr", int'(clr), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_st", int'(st_pkt), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_msg(2, 0);
        chk("after_rst_blocks", n_blk, 1);
        chk("after_rst_zeros", n_zero, 4);

`ifdef SHA2IND_ABORT_EN
        // abort while a block waits for ack
        ack_mode = 2;
        start_msg(1);
        drive_msg(1, 0);
        g = 0;
        while (!bus.blk_vld && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("abort_wait_vld", int'(bus.blk_vld), 1);
        abort = 1'b1;
        #1;
        chk("abort_vld", int'(bus.blk_vld), 0);
        chk("abort_st", int'(st_pkt), 0);
        chk("abort_rdy", int'(bus.msg_rdy), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        chk("abort_clr", int'(clr), 1);
        ack_mode = 0;
        @(posedge clk); #1;
        send_msg(1, 0);
        chk("abort_next_blocks", n_blk, 1);
        chk("abort_next_last", first_last, 1);
`endif

        // random lengths, gaps and ack timing
        for (int r = 0; r < 25; r++) begin
            ack_mode = 1;
            n  = $urandom_range(1, 20);
            nb = blocks_for(n);
            send_msg(n, $urandom_range(0, 40));
            chk("rand_blocks", n_blk, nb);
            chk("rand_first_last", first_last, int'(nb == 1));
            chk("rand_stores", n_st, nb * SLOTS);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
